ks_adder_pipe: RTL and testbench



---
 rtl/ks_adder_pipe.sv | 134 +++++++++++++
 tb/tb_ks_adder_pipe.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ks_adder_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with a valid/ready stream interface.
// One prefix level per stage; a single advance enable freezes everything under backpressure.
module ks_adder_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int K = $clog2(WIDTH);

  function automatic logic [WIDTH-1:0] level_g(input logic [WIDTH-1:0] g,
                                               input logic [WIDTH-1:0] p,
                                               input int               span);
    logic [WIDTH-1:0] r;
    r = g;
    for (int i = span; i < WIDTH; i++) begin
      r[i] = g[i] | (p[i] & g[i-span]);
    end
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] level_p(input logic [WIDTH-1:0] p,
                                               input int               span);
    logic [WIDTH-1:0] r;
    r = p;
    for (int i = span; i < WIDTH; i++) begin
      r[i] = p[i] & p[i-span];
    end
    return r;
  endfunction

  function automatic logic ovf_detect(input logic a_msb,
                                      input logic b_msb,
                                      input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  logic             en;
  logic             accept;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;
  logic [WIDTH-1:0] p_in;
  logic [WIDTH-1:0] g_in;

  // Stage k of these arrays holds the vectors after k prefix levels.
  logic [WIDTH-1:0] g_pk  [0:K];
  logic [WIDTH-1:0] p_pk  [0:K];
  logic [WIDTH-1:0] po_pk [0:K];
  logic [K:0]       amsb_pk;
  logic [K:0]       bmsb_pk;
  logic [K:0]       ceff_pk;
  logic [K:0]       vld_pk;

  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] sum_nx;

  assign en       = !(out_valid && !out_ready);
  assign in_ready = en && !flush;
  assign accept   = in_valid && in_ready;

  always_comb begin
    b_eff   = sub ? ~b : b;
    c_eff   = sub | cin;
    p_in    = a ^ b_eff;
    g_in    = a & b_eff;
    g_in[0] = (a[0] & b_eff[0]) | (p_in[0] & c_eff);
  end

  // ---- stage 0 register and prefix levels 1..K ----
  always_ff @(posedge clk) begin
    if (en) begin
      g_pk[0]  <= g_in;
      p_pk[0]  <= p_in;
      po_pk[0] <= p_in;
      for (int k = 1; k <= K; k++) begin
        g_pk[k]  <= level_g(g_pk[k-1], p_pk[k-1], 1 << (k - 1));
        p_pk[k]  <= level_p(p_pk[k-1], 1 << (k - 1));
        po_pk[k] <= po_pk[k-1];
      end
      amsb_pk <= {amsb_pk[K-1:0], a[WIDTH-1]};
      bmsb_pk <= {bmsb_pk[K-1:0], b_eff[WIDTH-1]};
      ceff_pk <= {ceff_pk[K-1:0], c_eff};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pk <= '0;
    end else if (flush) begin
      vld_pk <= '0;
    end else if (en) begin
      vld_pk <= {vld_pk[K-1:0], accept};
    end
  end

  // After the last level g_pk[K][i] is the group generate of bits i..0.
  assign carry  = {g_pk[K][WIDTH-2:0], ceff_pk[K]};
  assign sum_nx = po_pk[K] ^ carry;

  // ---- output stage ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      if (flush) begin
        out_valid <= 1'b0;
      end else if (en) begin
        out_valid <= vld_pk[K];
      end
      if (en && vld_pk[K]) begin
        sum  <= sum_nx;
        cout <= g_pk[K][WIDTH-1];
        ovf  <= ovf_detect(amsb_pk[K], bmsb_pk[K], sum_nx[WIDTH-1]);
      end
    end
  end

endmodule

// File: tb/tb_ks_adder_pipe.sv
// Scoreboard bench for ks_adder_pipe: a 16-bit instance with directed and random
// traffic, plus 4/32/64-bit instances under random add/sub and random backpressure.
module tb_ks_adder_pipe;

  localparam int W = 16;
  localparam int K = 4;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         lat;
    int           acc;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         rst_sw_n;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t exp_q[$];
  logic stream_done;

  ks_adder_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  // Reference: plain integer arithmetic. Returns {ovf, cout, sum[63:0]}.
  function automatic logic [65:0] ref_add(input int w, input logic [63:0] x, input logic [63:0] y,
                                          input logic ci, input logic sb);
    logic [64:0]        mask, ux, uy, full;
    logic signed [67:0] sx, sy, res, lim;
    logic               ov;
    mask = (65'd1 << w) - 65'd1;
    ux   = {1'b0, x} & mask;
    uy   = {1'b0, y} & mask;
    if (sb) full = ((ux - uy) & mask) | ((ux >= uy) ? (65'd1 << w) : 65'd0);
    else    full = ux + uy + {64'd0, ci};
    lim = 68'sd1 <<< (w - 1);
    sx  = $signed({3'b000, ux});
    sy  = $signed({3'b000, uy});
    if (ux[w-1]) sx = sx - (lim <<< 1);
    if (uy[w-1]) sy = sy - (lim <<< 1);
    res = sb ? (sx - sy) : (sx + sy + $signed({67'd0, ci}));
    ov  = (res >= lim) || (res < -lim);
    return {ov, full[w], full[63:0] & mask[63:0]};
  endfunction

  function automatic logic [17:0] mexp(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic ci, input logic sb);
    logic [65:0] r;
    r = ref_add(W, {48'd0, x}, {48'd0, y}, ci, sb);
    return {r[65], r[64], r[15:0]};
  endfunction

  task automatic chk(input string name, input logic [65:0] act, input logic [65:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %h required %h", name, act, req);
    end
  endtask

  // ev = {ovf, cout, sum} expected for this beat
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb2, input logic tc,
                      input logic ts, input logic lat, input logic [17:0] ev);
    exp_t e;
    int   tries;
    a = ta; b = tb2; cin = tc; sub = ts; in_valid = 1'b1;
    for (tries = 0; tries < 100; tries++) begin
      @(negedge clk);
      if (in_ready) break;
      @(posedge clk); #1;
    end
    if (tries == 100) begin
      checks++; errors++;
      $display("FAIL accept_timeout got in_ready=0 required 1");
    end else begin
      e.sum = ev[15:0]; e.cout = ev[16]; e.ovf = ev[17]; e.lat = lat; e.acc = cyc + 1;
      exp_q.push_back(e);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic send_rand();
    logic [W-1:0] ta, tb2;
    logic         tc, ts;
    ta = 16'($urandom); tb2 = 16'($urandom); tc = 1'($urandom); ts = 1'($urandom);
    send(ta, tb2, tc, ts, 1'b0, mexp(ta, tb2, tc, ts));
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Monitor: every handshake pops one expectation; a stalled output must not move.
  logic        held = 1'b0;
  logic [17:0] held_v;
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid) begin
      if (held) chk("stall_hold", {48'd0, ovf, cout, sum}, {48'd0, held_v});
      if (out_ready) begin
        held = 1'b0;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_result got %h required none", {ovf, cout, sum});
        end else begin
          e = exp_q.pop_front();
          chk("result", {48'd0, ovf, cout, sum}, {48'd0, e.ovf, e.cout, e.sum});
          if (e.lat) chk("latency", 66'(cyc - e.acc), 66'(K + 1));
        end
      end else begin
        held   = 1'b1;
        held_v = {ovf, cout, sum};
      end
    end else begin
      held = 1'b0;
    end
  end

  // Width sweep: independent instances with random traffic and random backpressure.
  for (genvar gi = 0; gi < 3; gi++) begin : g_sw
    localparam int SW = (gi == 0) ? 4 : ((gi == 1) ? 32 : 64);
    logic [SW-1:0] s_a, s_b, s_sum;
    logic          s_cin, s_sub, s_ivld, s_irdy, s_ovld, s_ordy, s_cout, s_ovf, s_flush;
    logic [65:0]   q[$];
    logic          done;

    ks_adder_pipe #(.WIDTH(SW)) dut_sw (
      .clk(clk), .rst_n(rst_sw_n), .flush(s_flush),
      .in_valid(s_ivld), .in_ready(s_irdy),
      .a(s_a), .b(s_b), .cin(s_cin), .sub(s_sub),
      .out_valid(s_ovld), .out_ready(s_ordy),
      .sum(s_sum), .cout(s_cout), .ovf(s_ovf)
    );

    initial begin
      int n;
      s_flush = 1'b0; s_ivld = 1'b0; s_a = '0; s_b = '0; s_cin = 1'b0; s_sub = 1'b0;
      done = 1'b0; n = 0;
      wait (rst_sw_n);
      @(posedge clk); #1;
      while (n < 60) begin
        s_ivld = ($urandom % 4) != 0;
        s_a    = SW'({$urandom, $urandom});
        s_b    = SW'({$urandom, $urandom});
        s_cin  = 1'($urandom);
        s_sub  = 1'($urandom);
        @(negedge clk);
        if (s_ivld && s_irdy) begin
          q.push_back(ref_add(SW, 64'(s_a), 64'(s_b), s_cin, s_sub));
          n++;
        end
        @(posedge clk); #1;
      end
      s_ivld = 1'b0;
      done   = 1'b1;
    end

    initial begin
      s_ordy = 1'b1;
      forever begin
        @(posedge clk); #1;
        s_ordy = ($urandom % 4) != 0;
      end
    end

    always @(negedge clk) begin
      logic [65:0] e;
      if (rst_sw_n && s_ovld && s_ordy) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL w%0d_unexpected got %h required none", SW, s_sum);
        end else begin
          e = q.pop_front();
          chk($sformatf("w%0d_result", SW), {64'(s_sum), s_cout, s_ovf},
              {64'(e[SW-1:0]), e[64], e[65]});
        end
      end
    end
  end

  initial begin
    logic all_done;
    rst_n = 1'b0; rst_sw_n = 1'b0; flush = 1'b0; out_ready = 1'b1; stream_done = 1'b0;
    in_valid = 1'($urandom); a = 16'($urandom); b = 16'($urandom);
    cin = 1'($urandom); sub = 1'($urandom);
    repeat (3) begin
      @(negedge clk);
      a = 16'($urandom); b = 16'($urandom); in_valid = 1'($urandom);
    end
    chk("reset_out_valid", 66'(out_valid), 66'd0);
    chk("reset_sum", 66'(sum), 66'd0);
    chk("reset_cout", 66'(cout), 66'd0);
    chk("reset_ovf", 66'(ovf), 66'd0);
    #2 rst_n = 1'b1; rst_sw_n = 1'b1;
    #1 chk("reset_in_ready", 66'(in_ready), 66'd1);
    in_valid = 1'b0;
    @(posedge clk); #1;

    // Directed add/subtract corners, expected values written out by hand.
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, {1'b0, 1'b1, 16'h0000});
    idle(8);
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, {1'b1, 1'b0, 16'h8000});
    send(16'h1234, 16'h0000, 1'b1, 1'b0, 1'b0, {1'b0, 1'b0, 16'h1235});
    send(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0, {1'b0, 1'b0, 16'hFFFE});
    send(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0, {1'b1, 1'b1, 16'h7FFF});
    send(16'h8000, 16'h0001, 1'b1, 1'b1, 1'b0, {1'b1, 1'b1, 16'h7FFF});
    send(16'h0005, 16'h0007, 1'b1, 1'b1, 1'b0, {1'b0, 1'b0, 16'hFFFE});
    idle(8);

    // Backpressure: 8 back-to-back beats, out_ready low 3 cycles after the first result.
    fork
      begin
        repeat (8) send_rand();
      end
      begin
        int t;
        for (t = 0; t < 50; t++) begin
          @(negedge clk);
          if (out_valid) break;
        end
        if (t == 50) begin
          checks++; errors++;
          $display("FAIL first_result_timeout got out_valid=0 required 1");
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("stall_in_ready", 66'(in_ready), 66'd0);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    idle(12);

    // Random stream with random backpressure.
    fork
      begin
        repeat (40) send_rand();
        stream_done = 1'b1;
      end
      begin
        while (!stream_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom % 3) != 0;
        end
        out_ready = 1'b1;
      end
    join
    idle(15);
    chk("stream_drained", 66'(exp_q.size()), 66'd0);

    // Flush with three beats in flight and a concurrent beat offered.
    repeat (3) send_rand();
    a = 16'($urandom); b = 16'($urandom); in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", 66'(in_ready), 66'd0);
    @(posedge clk); #1;
    exp_q.delete();
    flush = 1'b0; in_valid = 1'b0;
    send(16'h00F0, 16'h0F0F, 1'b1, 1'b0, 1'b1, mexp(16'h00F0, 16'h0F0F, 1'b1, 1'b0));
    idle(12);
    chk("flush_drained", 66'(exp_q.size()), 66'd0);

    // Asynchronous reset mid-stream while a result is presented.
    repeat (7) send_rand();
    #1;
    chk("pre_reset_out_valid", 66'(out_valid), 66'd1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_out_valid", 66'(out_valid), 66'd0);
    chk("async_reset_sum", 66'(sum), 66'd0);
    exp_q.delete();
    @(posedge clk);
    #3 rst_n = 1'b1;
    idle(12);
    chk("post_reset_in_ready", 66'(in_ready), 66'd1);
    send(16'hABCD, 16'h1234, 1'b0, 1'b1, 1'b1, mexp(16'hABCD, 16'h1234, 1'b0, 1'b1));
    idle(8);
    chk("post_reset_drained", 66'(exp_q.size()), 66'd0);

    all_done = 1'b0;
    for (int t = 0; t < 4000; t++) begin
      all_done = g_sw[0].done && g_sw[1].done && g_sw[2].done &&
                 g_sw[0].q.size() == 0 && g_sw[1].q.size() == 0 && g_sw[2].q.size() == 0;
      if (all_done) break;
      @(posedge clk);
    end
    chk("sweep_drained", 66'(all_done), 66'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
